thor2024_region_table_programmer: RTL and testbench



---
 rtl/thor2024_region_table_programmer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_thor2024_region_table_programmer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thor2024_region_table_programmer.sv
`default_nettype none
// ============================================================================
// Module      : thor2024_region_table_programmer
// Description : Bus initiator that programs the PMA region table (8 regions x
//               4 words) from a descriptor store. For each selected region it
//               unlocks, writes pmt/cta/at, relocks and optionally reads back.
// Revision    : 1.0 - initial release
// ============================================================================
module thor2024_region_table_programmer #(
    parameter logic [31:0] RGN_BASE = 32'hFEEF0000,
    parameter int          ABITS    = 48,
    parameter bit          VERIFY   = 1'b1,
    parameter int          TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   region_mask,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [2:0]   err_region,
    output logic [1:0]   err_field,
    output logic [4:0]   desc_adr,
    input  logic [127:0] desc_dat,
    output logic         req_cyc,
    output logic         req_stb,
    output logic         req_we,
    output logic [31:0]  req_padr,
    output logic [15:0]  req_sel,
    output logic [127:0] req_data1,
    input  logic         resp_ack,
    input  logic         resp_err,
    input  logic [127:0] resp_dat
);

    localparam logic [3:0] C_IDLE  = 4'd0;
    localparam logic [3:0] C_SEL   = 4'd1;
    localparam logic [3:0] C_FETCH = 4'd2;
    localparam logic [3:0] C_DWAIT = 4'd3;
    localparam logic [3:0] C_REQ   = 4'd4;
    localparam logic [3:0] C_ACKW  = 4'd5;
    localparam logic [3:0] C_GAP   = 4'd6;
    localparam logic [3:0] C_FIN   = 4'd7;
    localparam logic [3:0] C_FAIL  = 4'd8;

    localparam logic [31:0] C_UNLK = 32'h554E4C4B;
    localparam logic [31:0] C_LOCK = 32'h4C4F434B;

    localparam int            C_TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [C_TW-1:0] C_TMO_LAST = C_TW'(TIMEOUT - 1);

    // Operation index within a region:
    //   0 = UNLK write (f3), 1..3 = f0..f2 writes, 4 = LOCK write (f3),
    //   5..7 = f0..f2 readbacks. The field is op[1:0]-1 in every case.
    function automatic logic [1:0] field_of(input logic [2:0] op);
        return op[1:0] - 2'd1;
    endfunction

    function automatic logic is_write(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    logic [3:0]      state_q,    state_d;
    logic [3:0]      scan_q,     scan_d;
    logic [2:0]      op_q,       op_d;
    logic [7:0]      mask_q,     mask_d;
    logic [127:0]    desc_q,     desc_d;
    logic [C_TW-1:0] tmo_q,      tmo_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            err_q,      err_d;
    logic [2:0]      err_rgn_q,  err_rgn_d;
    logic [1:0]      err_fld_q,  err_fld_d;
    logic [4:0]      dadr_q,     dadr_d;
    logic            cyc_q,      cyc_d;
    logic            we_q,       we_d;
    logic [31:0]     padr_q,     padr_d;
    logic [15:0]     sel_q,      sel_d;
    logic [127:0]    data1_q,    data1_d;

    logic            w_found;
    logic [3:0]      w_found_idx;
    logic            w_mismatch;
    logic            w_fail;
    logic            w_drop;

    // Lowest region at or above the scan pointer whose mask bit is set.
    always_comb begin
        w_found     = 1'b0;
        w_found_idx = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if ((i >= int'(scan_q)) && mask_q[i]) begin
                w_found     = 1'b1;
                w_found_idx = 4'(i);
            end
        end
    end

    // Readback compare: pmt/cta only carry ABITS significant bits, at is full width.
    always_comb begin
        if (field_of(op_q) == 2'd2) begin
            w_mismatch = (resp_dat != desc_q);
        end else begin
            w_mismatch = (resp_dat[ABITS-1:0] != desc_q[ABITS-1:0]);
        end
    end

    // Sequencer next-state and request/status register updates.
    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        op_d      = op_q;
        mask_d    = mask_q;
        desc_d    = desc_q;
        tmo_d     = tmo_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_rgn_d = err_rgn_q;
        err_fld_d = err_fld_q;
        dadr_d    = dadr_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        padr_d    = padr_q;
        sel_d     = sel_q;
        data1_d   = data1_q;
        w_fail    = 1'b0;
        w_drop    = 1'b0;

        case (state_q)
            C_IDLE, C_FIN, C_FAIL: begin
                state_d = C_IDLE;
                if (start) begin
                    mask_d    = region_mask;
                    scan_d    = 4'd0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    err_rgn_d = 3'd0;
                    err_fld_d = 2'd0;
                    busy_d    = 1'b1;
                    state_d   = C_SEL;
                end
            end
            C_SEL: begin
                if (w_found) begin
                    scan_d  = w_found_idx;
                    op_d    = 3'd0;
                    state_d = C_REQ;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = C_FIN;
                end
            end
            C_FETCH: state_d = C_DWAIT;
            C_DWAIT: begin
                desc_d  = desc_dat;
                state_d = C_REQ;
            end
            C_REQ:   state_d = C_ACKW;
            C_ACKW: begin
                if (resp_err) begin
                    w_fail = 1'b1;
                end else if (resp_ack) begin
                    if (!is_write(op_q) && w_mismatch) begin
                        w_fail = 1'b1;
                    end else begin
                        w_drop  = 1'b1;
                        state_d = C_GAP;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    w_fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            C_GAP: begin
                if ((op_q == 3'd7) || ((op_q == 3'd4) && !VERIFY)) begin
                    scan_d  = scan_q + 4'd1;
                    state_d = C_SEL;
                end else begin
                    op_d    = op_q + 3'd1;
                    state_d = (op_d == 3'd4) ? C_REQ : C_FETCH;
                end
            end
            default: state_d = C_IDLE;
        endcase

        if (w_fail) begin
            state_d   = C_FAIL;
            err_d     = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            err_rgn_d = scan_q[2:0];
            err_fld_d = field_of(op_q);
            w_drop    = 1'b1;
        end

        if (w_drop) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            padr_d  = 32'd0;
            sel_d   = 16'd0;
            data1_d = 128'd0;
        end

        // Load the whole request on entry to REQ so it is stable through ACKW.
        if (state_d == C_REQ) begin
            tmo_d  = '0;
            cyc_d  = 1'b1;
            sel_d  = 16'hFFFF;
            we_d   = is_write(op_d);
            padr_d = RGN_BASE | {23'd0, scan_d[2:0], field_of(op_d), 4'd0};
            if (op_d == 3'd0) begin
                data1_d = {96'd0, C_UNLK};
            end else if (op_d == 3'd4) begin
                data1_d = {96'd0, C_LOCK};
            end else if (is_write(op_d)) begin
                data1_d = desc_d;
            end else begin
                data1_d = 128'd0;
            end
        end

        // Present the descriptor address for the whole FETCH/DWAIT window.
        if (state_d == C_FETCH) begin
            dadr_d = {scan_d[2:0], field_of(op_d)};
        end
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= C_IDLE;
            scan_q    <= 4'd0;
            op_q      <= 3'd0;
            mask_q    <= 8'd0;
            desc_q    <= 128'd0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_rgn_q <= 3'd0;
            err_fld_q <= 2'd0;
            dadr_q    <= 5'd0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            padr_q    <= 32'd0;
            sel_q     <= 16'd0;
            data1_q   <= 128'd0;
        end else begin
            state_q   <= state_d;
            scan_q    <= scan_d;
            op_q      <= op_d;
            mask_q    <= mask_d;
            desc_q    <= desc_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_rgn_q <= err_rgn_d;
            err_fld_q <= err_fld_d;
            dadr_q    <= dadr_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            padr_q    <= padr_d;
            sel_q     <= sel_d;
            data1_q   <= data1_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_region = err_rgn_q;
    assign err_field  = err_fld_q;
    assign desc_adr   = dadr_q;
    assign req_cyc    = cyc_q;
    assign req_stb    = cyc_q;
    assign req_we     = we_q;
    assign req_padr   = padr_q;
    assign req_sel    = sel_q;
    assign req_data1  = data1_q;

endmodule
`default_nettype wire

// File: tb/tb_thor2024_region_table_programmer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_thor2024_region_table_programmer
// Description : Bench for the region table programmer: descriptor store,
//               region table responder and a transaction-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thor2024_region_table_programmer;

    localparam logic [31:0] C_BASE = 32'hFEEF0000;
    localparam logic [31:0] C_UNLK = 32'h554E4C4B;
    localparam logic [31:0] C_LOCK = 32'h4C4F434B;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic a_start, a_busy, a_done, a_err, a_cyc, a_stb, a_we;
    logic [7:0] a_mask; logic [2:0] a_er; logic [1:0] a_ef; logic [4:0] a_dadr;
    logic [31:0] a_padr; logic [15:0] a_sel; logic [127:0] a_data;
    logic b_start, b_busy, b_done, b_err, b_cyc, b_stb, b_we;
    logic [7:0] b_mask; logic [2:0] b_er; logic [1:0] b_ef; logic [4:0] b_dadr;
    logic [31:0] b_padr; logic [15:0] b_sel; logic [127:0] b_data;

    logic [127:0] desc_dat, resp_dat;
    logic resp_ack, resp_err;
    logic use_b;

    thor2024_region_table_programmer #(.VERIFY(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(a_start), .region_mask(a_mask),
        .busy(a_busy), .done(a_done), .err(a_err), .err_region(a_er), .err_field(a_ef),
        .desc_adr(a_dadr), .desc_dat(desc_dat),
        .req_cyc(a_cyc), .req_stb(a_stb), .req_we(a_we), .req_padr(a_padr),
        .req_sel(a_sel), .req_data1(a_data),
        .resp_ack(resp_ack), .resp_err(resp_err), .resp_dat(resp_dat));

    thor2024_region_table_programmer #(.VERIFY(1'b0)) u_dut_nv (
        .clk(clk), .rst(rst), .start(b_start), .region_mask(b_mask),
        .busy(b_busy), .done(b_done), .err(b_err), .err_region(b_er), .err_field(b_ef),
        .desc_adr(b_dadr), .desc_dat(desc_dat),
        .req_cyc(b_cyc), .req_stb(b_stb), .req_we(b_we), .req_padr(b_padr),
        .req_sel(b_sel), .req_data1(b_data),
        .resp_ack(resp_ack), .resp_err(resp_err), .resp_dat(resp_dat));

    // Only one initiator is active at a time; the responder serves whichever it is.
    wire         bus_cyc  = a_cyc | b_cyc;
    wire         bus_stb  = b_cyc ? b_stb  : a_stb;
    wire         bus_we   = b_cyc ? b_we   : a_we;
    wire [31:0]  bus_padr = b_cyc ? b_padr : a_padr;
    wire [15:0]  bus_sel  = b_cyc ? b_sel  : a_sel;
    wire [127:0] bus_data = b_cyc ? b_data : a_data;
    wire [4:0]   bus_dadr = use_b ? b_dadr : a_dadr;
    wire [2:0]   w_rg     = bus_padr[8:6];
    wire [1:0]   w_fd     = bus_padr[5:4];

    logic [127:0] desc_mem [32];
    always @(posedge clk) desc_dat <= desc_mem[bus_dadr];

    logic [127:0] rt [8][4];
    logic         log_we   [64];
    logic [31:0]  log_padr [64];
    logic [127:0] log_data [64];
    int txn_cnt, proto_bad, wcnt;
    logic in_txn, gap_chk, hold_we;
    logic [31:0] hold_padr; logic [127:0] hold_data;
    int rsp_delay, hang_idx, both_idx, bad_rgn, bad_fld;
    logic [127:0] bad_xor;

    wire w_viol = (gap_chk && bus_cyc) ||
                  (bus_cyc && !resp_ack && !resp_err &&
                   (!bus_stb || (bus_sel !== 16'hFFFF) ||
                    (in_txn && ((bus_padr !== hold_padr) || (bus_we !== hold_we) || (bus_data !== hold_data)))));

    // Region table responder: all regions start locked; locked regions ignore f0-f2 writes.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_ack <= 1'b0; resp_err <= 1'b0; resp_dat <= '0;
            txn_cnt <= 0; proto_bad <= 0; wcnt <= 0; in_txn <= 1'b0; gap_chk <= 1'b0;
            hold_we <= 1'b0; hold_padr <= '0; hold_data <= '0;
            for (int r = 0; r < 8; r++)
                for (int f = 0; f < 4; f++)
                    rt[r][f] <= (f == 3) ? {96'd0, C_LOCK} : 128'd0;
        end else begin
            resp_ack <= 1'b0; resp_err <= 1'b0;
            gap_chk  <= resp_ack | resp_err;
            if (w_viol) proto_bad <= proto_bad + 1;
            if (bus_cyc && !resp_ack && !resp_err) begin
                if (!in_txn) begin
                    hold_padr <= bus_padr; hold_we <= bus_we; hold_data <= bus_data;
                end
                if ((in_txn ? wcnt : 0) >= rsp_delay && txn_cnt != hang_idx) begin
                    in_txn   <= 1'b0;
                    resp_ack <= 1'b1;
                    resp_err <= (txn_cnt == both_idx);
                    if (txn_cnt < 64) begin
                        log_we[txn_cnt] <= bus_we; log_padr[txn_cnt] <= bus_padr; log_data[txn_cnt] <= bus_data;
                    end
                    txn_cnt <= txn_cnt + 1;
                    if (bus_we) begin
                        if (w_fd == 2'd3) rt[w_rg][3] <= {96'd0, bus_data[31:0]};
                        else if (rt[w_rg][3][31:0] != C_LOCK) rt[w_rg][w_fd] <= bus_data;
                    end else begin
                        resp_dat <= rt[w_rg][w_fd] ^
                                    (((int'(w_rg) == bad_rgn) && (int'(w_fd) == bad_fld)) ? bad_xor : 128'd0);
                    end
                end else begin
                    in_txn <= 1'b1;
                    wcnt   <= (in_txn ? wcnt : 0) + 1;
                end
            end else if (!bus_cyc) begin
                in_txn <= 1'b0;
            end
        end
    end

    // Reference model: the ordered list of bus transactions a pass must produce.
    logic         exp_we   [64];
    logic [31:0]  exp_padr [64];
    logic [127:0] exp_data [64];
    int exp_n;
    int checks = 0;
    int errors = 0;

    task automatic add_exp(input logic we, input int r, input int f, input logic [127:0] d);
        exp_we[exp_n] = we; exp_padr[exp_n] = C_BASE + 32'(r * 64 + f * 16); exp_data[exp_n] = d;
        exp_n++;
    endtask

    task automatic build_exp(input logic [7:0] mask, input bit verify);
        exp_n = 0;
        for (int r = 0; r < 8; r++) begin
            if (mask[r]) begin
                add_exp(1'b1, r, 3, {96'd0, C_UNLK});
                for (int f = 0; f < 3; f++) add_exp(1'b1, r, f, desc_mem[r * 4 + f]);
                add_exp(1'b1, r, 3, {96'd0, C_LOCK});
                if (verify) for (int f = 0; f < 3; f++) add_exp(1'b0, r, f, 128'd0);
            end
        end
    endtask

    // Number of the first n logged transactions that differ from the model.
    function automatic int log_diff(input int n);
        int bad = 0;
        for (int i = 0; i < n && i < 64; i++)
            if (log_we[i] !== exp_we[i] || log_padr[i] !== exp_padr[i] ||
                (exp_we[i] && log_data[i] !== exp_data[i])) bad++;
        return bad;
    endfunction

    task automatic randomize_desc();
        for (int i = 0; i < 32; i++) desc_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rsp_delay = 0; hang_idx = -1; both_idx = -1; bad_rgn = -1; bad_fld = -1; bad_xor = 128'd1;
        use_b = 1'b0; a_start = 1'b0; b_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit b, input logic [7:0] m);
        @(negedge clk);
        if (b) begin b_mask = m; b_start = 1'b1; end else begin a_mask = m; a_start = 1'b1; end
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int lim, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        for (int i = 0; i < lim; i++) begin
            if ((b ? b_done : a_done) && !(b ? b_busy : a_busy)) begin ok = 1'b1; break; end
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({a_busy, a_done, a_err, a_er, a_ef, a_dadr, a_cyc, a_stb, a_we, a_padr, a_sel, a_data} !== 192'd0) begin
            errors++; $display("FAIL reset_outputs_a: got busy=%b done=%b cyc=%b padr=%h want all 0", a_busy, a_done, a_cyc, a_padr);
        end
        checks++;
        if ({b_busy, b_done, b_err, b_er, b_ef, b_dadr, b_cyc, b_stb, b_we, b_padr, b_sel, b_data} !== 192'd0) begin
            errors++; $display("FAIL reset_outputs_b: got busy=%b done=%b cyc=%b padr=%h want all 0", b_busy, b_done, b_cyc, b_padr);
        end
    endtask

    task automatic check_table(input string nm, input logic [7:0] mask);
        for (int r = 0; r < 8; r++) begin
            logic [415:0] got, want;
            got  = {rt[r][0], rt[r][1], rt[r][2], rt[r][3][31:0]};
            want = mask[r] ? {desc_mem[r*4], desc_mem[r*4+1], desc_mem[r*4+2], C_LOCK} : {384'd0, C_LOCK};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL %s_table_r%0d: got lock=%h f0=%h want lock=%h f0=%h", nm, r, got[31:0], got[415:288], want[31:0], want[415:288]);
            end
        end
    endtask

    task automatic test_single();
        bit ok; int cyc;
        do_reset(); randomize_desc(); build_exp(8'h02, 1'b1);
        pulse_start(1'b0, 8'h02);
        wait_done(1'b0, 500, ok, cyc);
        checks++; if (!ok || a_err !== 1'b0) begin errors++; $display("FAIL single_done: got ok=%b err=%b want ok=1 err=0", ok, a_err); end
        checks++; if (txn_cnt !== 8) begin errors++; $display("FAIL single_count: got %0d want 8", txn_cnt); end
        checks++; if (log_diff(8) !== 0) begin errors++; $display("FAIL single_seq: got %0d bad txns want 0", log_diff(8)); end
        checks++; if (proto_bad !== 0) begin errors++; $display("FAIL single_protocol: got %0d violations want 0", proto_bad); end
        check_table("single", 8'h02);
        repeat (5) @(negedge clk);
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL single_done_hold: got %b want 1", a_done); end
    endtask

    task automatic test_random();
        bit ok; int cyc; logic [7:0] m;
        for (int it = 0; it < 4; it++) begin
            do_reset(); randomize_desc();
            rsp_delay = $urandom_range(0, 3);
            m = 8'($urandom);
            build_exp(m, 1'b1);
            pulse_start(1'b0, m);
            wait_done(1'b0, 3000, ok, cyc);
            checks++; if (!ok || a_err !== 1'b0) begin errors++; $display("FAIL rand%0d_done: got ok=%b err=%b want ok=1 err=0 mask=%h", it, ok, a_err, m); end
            checks++; if (txn_cnt !== exp_n || log_diff(exp_n) !== 0) begin errors++; $display("FAIL rand%0d_seq: got %0d txns %0d bad want %0d txns 0 bad", it, txn_cnt, log_diff(exp_n), exp_n); end
            checks++; if (proto_bad !== 0) begin errors++; $display("FAIL rand%0d_protocol: got %0d want 0", it, proto_bad); end
            check_table("rand", m);
        end
    endtask

    task automatic test_mask_zero();
        do_reset();
        pulse_start(1'b0, 8'h00);
        checks++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL zero_busy: got busy=%b done=%b want 1 0", a_busy, a_done); end
        @(negedge clk);
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL zero_done: got busy=%b done=%b err=%b want 0 1 0", a_busy, a_done, a_err); end
        checks++; if (txn_cnt !== 0) begin errors++; $display("FAIL zero_bus: got %0d txns want 0", txn_cnt); end
    endtask

    task automatic test_no_verify();
        bit ok; int cyc;
        do_reset(); randomize_desc(); use_b = 1'b1;
        build_exp(8'h81, 1'b0);
        pulse_start(1'b1, 8'h81);
        wait_done(1'b1, 1000, ok, cyc);
        checks++; if (!ok || b_err !== 1'b0) begin errors++; $display("FAIL nv_done: got ok=%b err=%b want ok=1 err=0", ok, b_err); end
        checks++; if (txn_cnt !== 10 || log_diff(10) !== 0) begin errors++; $display("FAIL nv_seq: got %0d txns %0d bad want 10 txns 0 bad", txn_cnt, log_diff(10)); end
        check_table("nv", 8'h81);
        use_b = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok; int cyc;
        do_reset(); randomize_desc(); hang_idx = 2;
        pulse_start(1'b0, 8'h01);
        wait_done(1'b0, 600, ok, cyc);
        checks++; if (!ok || a_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got ok=%b err=%b want ok=1 err=1", ok, a_err); end
        checks++; if (a_er !== 3'd0 || a_ef !== 2'd1) begin errors++; $display("FAIL tmo_where: got region=%0d field=%0d want 0 1", a_er, a_ef); end
        checks++; if (a_cyc !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b1) begin errors++; $display("FAIL tmo_state: got cyc=%b busy=%b done=%b want 0 0 1", a_cyc, a_busy, a_done); end
        checks++; if (cyc < 260 || cyc > 275) begin errors++; $display("FAIL tmo_length: got %0d cycles want 260..275", cyc); end
        checks++; if (txn_cnt !== 2) begin errors++; $display("FAIL tmo_count: got %0d want 2", txn_cnt); end
    endtask

    task automatic test_bad_read();
        bit ok; int cyc;
        do_reset(); randomize_desc(); rsp_delay = $urandom_range(0, 2);
        bad_rgn = 3; bad_fld = 2; bad_xor = 128'd1;
        build_exp(8'hFF, 1'b1);
        pulse_start(1'b0, 8'hFF);
        wait_done(1'b0, 3000, ok, cyc);
        checks++; if (!ok || a_err !== 1'b1) begin errors++; $display("FAIL bad_err: got ok=%b err=%b want ok=1 err=1", ok, a_err); end
        checks++; if (a_er !== 3'd3 || a_ef !== 2'd2) begin errors++; $display("FAIL bad_where: got region=%0d field=%0d want 3 2", a_er, a_ef); end
        repeat (10) @(negedge clk);
        checks++; if (txn_cnt !== 32 || log_diff(32) !== 0) begin errors++; $display("FAIL bad_stop: got %0d txns %0d bad want 32 txns 0 bad", txn_cnt, log_diff(32)); end
    endtask

    task automatic test_compare_width();
        bit ok; int cyc;
        logic [127:0] one;
        one = 128'd1;
        do_reset(); randomize_desc();
        bad_rgn = 2; bad_fld = 0; bad_xor = one << 100;
        pulse_start(1'b0, 8'h04);
        wait_done(1'b0, 500, ok, cyc);
        checks++; if (!ok || a_err !== 1'b0) begin errors++; $display("FAIL width_upper_ignored: got ok=%b err=%b want ok=1 err=0", ok, a_err); end
        do_reset();
        bad_rgn = 2; bad_fld = 0; bad_xor = one << 47;
        pulse_start(1'b0, 8'h04);
        wait_done(1'b0, 500, ok, cyc);
        checks++; if (!ok || a_err !== 1'b1 || a_ef !== 2'd0 || a_er !== 3'd2) begin errors++; $display("FAIL width_bit47: got ok=%b err=%b region=%0d field=%0d want 1 1 2 0", ok, a_err, a_er, a_ef); end
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc;
        do_reset(); randomize_desc(); rsp_delay = 6;
        pulse_start(1'b0, 8'h0F);
        for (int i = 0; i < 50 && !a_cyc; i++) @(negedge clk);
        @(negedge clk);
        checks++; if (a_cyc !== 1'b1) begin errors++; $display("FAIL rmid_inflight: got cyc=%b want 1", a_cyc); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_done, a_err, a_er, a_ef, a_dadr, a_cyc, a_stb, a_we, a_padr, a_sel, a_data} !== 192'd0) begin
            errors++; $display("FAIL rmid_outputs: got busy=%b cyc=%b stb=%b padr=%h want all 0", a_busy, a_cyc, a_stb, a_padr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; rsp_delay = 0;
        repeat (3) @(negedge clk);
        checks++; if (a_busy !== 1'b0 || a_cyc !== 1'b0 || txn_cnt !== 0) begin errors++; $display("FAIL rmid_no_resume: got busy=%b cyc=%b txns=%0d want 0 0 0", a_busy, a_cyc, txn_cnt); end
        build_exp(8'h0F, 1'b1);
        pulse_start(1'b0, 8'h0F);
        wait_done(1'b0, 2000, ok, cyc);
        checks++; if (!ok || a_err !== 1'b0 || txn_cnt !== 32 || log_diff(32) !== 0) begin errors++; $display("FAIL rmid_clean_pass: got ok=%b err=%b txns=%0d bad=%0d want 1 0 32 0", ok, a_err, txn_cnt, log_diff(32)); end
        check_table("rmid", 8'h0F);
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc;
        do_reset(); randomize_desc(); rsp_delay = 1;
        build_exp(8'h05, 1'b1);
        pulse_start(1'b0, 8'h05);
        repeat (4) @(negedge clk);
        pulse_start(1'b0, 8'hFF);
        wait_done(1'b0, 2000, ok, cyc);
        repeat (10) @(negedge clk);
        checks++; if (!ok || a_err !== 1'b0 || txn_cnt !== 16 || log_diff(16) !== 0) begin errors++; $display("FAIL b2b_single_pass: got ok=%b err=%b txns=%0d bad=%0d want 1 0 16 0", ok, a_err, txn_cnt, log_diff(16)); end
        do_reset(); randomize_desc(); both_idx = 3;
        pulse_start(1'b0, 8'h01);
        wait_done(1'b0, 500, ok, cyc);
        checks++; if (!ok || a_err !== 1'b1 || a_er !== 3'd0 || a_ef !== 2'd2 || txn_cnt !== 4) begin errors++; $display("FAIL both_ack_err: got ok=%b err=%b region=%0d field=%0d txns=%0d want 1 1 0 2 4", ok, a_err, a_er, a_ef, txn_cnt); end
        pulse_start(1'b0, 8'h00);
        checks++; if (a_err !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL restart_clears: got err=%b done=%b want 0 0", a_err, a_done); end
    endtask

    initial begin
        a_start = 1'b0; b_start = 1'b0; a_mask = 8'd0; b_mask = 8'd0; use_b = 1'b0;
        rsp_delay = 0; hang_idx = -1; both_idx = -1; bad_rgn = -1; bad_fld = -1; bad_xor = 128'd1;
        randomize_desc();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_single();
        test_random();
        test_mask_zero();
        test_no_verify();
        test_timeout();
        test_bad_read();
        test_compare_width();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion within time limit want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
